urna_apuracao: RTL and testbench

URNA_APURACAO -- requirements
Module: urna_apuracao

---
 rtl/urna_apuracao_if.sv | 30 +++
 rtl/urna_apuracao.sv | 191 +++++++++++++++++++
 tb/tb_urna_apuracao.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/urna_apuracao_if.sv
// Bus between the voting stage and the tally block: the vote counts and the
// end-of-election level go in, the tally results and the display entry come out.
interface urna_apuracao_if;
  logic       Finish;
  logic [7:0] C1;
  logic [7:0] C2;
  logic [7:0] C3;
  logic [7:0] C4;
  logic [7:0] Nulo;

  logic [2:0]  Winner;
  logic        Tie;
  logic [10:0] Total;
  logic        Done;
  logic [2:0]  Show_Id;
  logic [7:0]  Show_Count;
  logic        Show_Valid;

  // The voting stage drives the counts and Finish and reads the results.
  modport master (
    output Finish, C1, C2, C3, C4, Nulo,
    input  Winner, Tie, Total, Done, Show_Id, Show_Count, Show_Valid
  );

  // The tally block reads the counts and Finish and drives the results.
  modport slave (
    input  Finish, C1, C2, C3, C4, Nulo,
    output Winner, Tie, Total, Done, Show_Id, Show_Count, Show_Valid
  );
endinterface

// File: rtl/urna_apuracao.sv
// Election tally: on a rising edge of Finish the counts are snapshotted,
// compared one candidate per cycle to find the winner or a tie, summed into
// the total, and then shown round-robin as (id, count) display entries.
module urna_apuracao #(
  parameter int unsigned DISPLAY_CYCLES = 4
) (
  input logic             i_Clock,
  input logic             i_Reset,
  urna_apuracao_if.slave  io_urna
);

  typedef enum logic [1:0] {IDLE, CMP, SHOW} state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_finish_d;
  logic        w_start;

  logic [7:0]  r_c1, r_c2, r_c3, r_c4, r_nulo;
  logic [2:0]  r_step;
  logic [10:0] r_sum;
  logic [7:0]  r_max;
  logic [2:0]  r_best;
  logic        r_shared;

  logic [2:0]  r_winner;
  logic        r_tie;
  logic [10:0] r_total;
  logic        r_done;
  logic [2:0]  r_show_id;
  logic [7:0]  r_show_count;
  logic        r_show_valid;
  logic [7:0]  r_disp_cnt;

  logic        w_load;
  logic        w_step;
  logic        w_final;
  logic        w_show;
  logic [7:0]  w_operand;
  logic [10:0] w_addend;
  logic [2:0]  w_next_id;
  logic [7:0]  w_next_count;

  assign w_start = io_urna.Finish & ~r_finish_d;

  // State register; reset always returns to IDLE and wins over a start event.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic: a start is only honoured outside CMP; step 5 closes CMP.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next_state = CMP;
      CMP:     if (r_step == 3'd5) w_next_state = SHOW;
      SHOW:    if (w_start) w_next_state = CMP;
      default: w_next_state = IDLE;
    endcase
  end

  // Control strobes for the datapath, decoded from the current state.
  always_comb begin
    w_load  = 1'b0;
    w_step  = 1'b0;
    w_final = 1'b0;
    w_show  = 1'b0;
    case (r_state)
      IDLE: w_load = w_start;
      CMP: begin
        w_step  = (r_step != 3'd5);
        w_final = (r_step == 3'd5);
      end
      SHOW: begin
        w_load = w_start;
        w_show = ~w_start;
      end
      default: ;
    endcase
  end

  // Operand for the current comparison step; step 4 also folds in the null votes.
  always_comb begin
    w_operand = r_c4;
    case (r_step)
      3'd1:    w_operand = r_c1;
      3'd2:    w_operand = r_c2;
      3'd3:    w_operand = r_c3;
      default: w_operand = r_c4;
    endcase
    w_addend = {3'd0, w_operand} + ((r_step == 3'd4) ? {3'd0, r_nulo} : 11'd0);
  end

  // Next display entry (1..5 wrapping) and its latched count.
  always_comb begin
    w_next_id    = (r_show_id == 3'd5) ? 3'd1 : r_show_id + 3'd1;
    w_next_count = r_c1;
    case (w_next_id)
      3'd1:    w_next_count = r_c1;
      3'd2:    w_next_count = r_c2;
      3'd3:    w_next_count = r_c3;
      3'd4:    w_next_count = r_c4;
      default: w_next_count = r_nulo;
    endcase
  end

  // Datapath: snapshot, accumulate/compare, publish results, rotate the display.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_finish_d   <= 1'b0;
      r_c1         <= '0;
      r_c2         <= '0;
      r_c3         <= '0;
      r_c4         <= '0;
      r_nulo       <= '0;
      r_step       <= '0;
      r_sum        <= '0;
      r_max        <= '0;
      r_best       <= '0;
      r_shared     <= 1'b0;
      r_winner     <= '0;
      r_tie        <= 1'b0;
      r_total      <= '0;
      r_done       <= 1'b0;
      r_show_id    <= '0;
      r_show_count <= '0;
      r_show_valid <= 1'b0;
      r_disp_cnt   <= '0;
    end else begin
      r_finish_d <= io_urna.Finish;
      if (w_load) begin
        r_c1         <= io_urna.C1;
        r_c2         <= io_urna.C2;
        r_c3         <= io_urna.C3;
        r_c4         <= io_urna.C4;
        r_nulo       <= io_urna.Nulo;
        r_step       <= 3'd1;
        r_sum        <= '0;
        r_max        <= '0;
        r_best       <= '0;
        r_shared     <= 1'b0;
        r_winner     <= '0;
        r_tie        <= 1'b0;
        r_total      <= '0;
        r_done       <= 1'b0;
        r_show_id    <= '0;
        r_show_count <= '0;
        r_show_valid <= 1'b0;
        r_disp_cnt   <= '0;
      end else if (w_step) begin
        r_sum  <= r_sum + w_addend;
        r_step <= r_step + 3'd1;
        if (w_operand > r_max) begin
          r_max    <= w_operand;
          r_best   <= r_step;
          r_shared <= 1'b0;
        end else if ((w_operand == r_max) && (w_operand != 8'd0)) begin
          r_shared <= 1'b1;
        end
      end else if (w_final) begin
        r_total      <= r_sum;
        r_done       <= 1'b1;
        r_winner     <= (r_max == 8'd0 || r_shared) ? 3'd0 : r_best;
        r_tie        <= (r_max != 8'd0) && r_shared;
        r_show_valid <= 1'b1;
        r_show_id    <= 3'd1;
        r_show_count <= r_c1;
        r_disp_cnt   <= '0;
      end else if (w_show) begin
        if (r_disp_cnt == 8'(DISPLAY_CYCLES - 1)) begin
          r_disp_cnt   <= '0;
          r_show_id    <= w_next_id;
          r_show_count <= w_next_count;
        end else begin
          r_disp_cnt <= r_disp_cnt + 8'd1;
        end
      end
    end
  end

  assign io_urna.Winner     = r_winner;
  assign io_urna.Tie        = r_tie;
  assign io_urna.Total      = r_total;
  assign io_urna.Done       = r_done;
  assign io_urna.Show_Id    = r_show_id;
  assign io_urna.Show_Count = r_show_count;
  assign io_urna.Show_Valid = r_show_valid;

endmodule

// File: tb/tb_urna_apuracao.sv
// Bench for the election tally: directed corner cases plus randomized
// elections checked against a plain-arithmetic model of who wins.
module tb_urna_apuracao;

  localparam int DC = 2;

  logic clock = 1'b0;
  logic reset;
  int   testsRun = 0;
  int   testsFailed = 0;
  logic [7:0] mC [1:5];

  urna_apuracao_if bus ();

  urna_apuracao #(.DISPLAY_CYCLES(DC)) dut (
    .i_Clock (clock),
    .i_Reset (reset),
    .io_urna (bus)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: highest candidate count wins; a shared nonzero top is a tie.
  task automatic tallyModel(output int w, output int t, output int total);
    int maxv;
    int nmax;
    maxv = 0; nmax = 0; total = 0; w = 0; t = 0;
    for (int i = 1; i <= 5; i++) total += int'(mC[i]);
    for (int i = 1; i <= 4; i++) if (int'(mC[i]) > maxv) maxv = int'(mC[i]);
    for (int i = 1; i <= 4; i++) if (int'(mC[i]) == maxv) nmax++;
    if (maxv == 0) begin
      w = 0; t = 0;
    end else if (nmax > 1) begin
      w = 0; t = 1;
    end else begin
      for (int i = 1; i <= 4; i++) if (int'(mC[i]) == maxv) w = i;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3,
                               input logic [7:0] c4, input logic [7:0] n);
    mC[1] = c1; mC[2] = c2; mC[3] = c3; mC[4] = c4; mC[5] = n;
    bus.C1 = c1; bus.C2 = c2; bus.C3 = c3; bus.C4 = c4; bus.Nulo = n;
    bus.Finish = 1'b1;
  endtask

  task automatic scrambleInputs;
    bus.C1 = 8'($urandom); bus.C2 = 8'($urandom); bus.C3 = 8'($urandom);
    bus.C4 = 8'($urandom); bus.Nulo = 8'($urandom);
  endtask

  // Start event on the next edge (k); results must appear exactly at k+5.
  task automatic expectTally(input bit glitchInCmp);
    int ew, et, etot;
    tallyModel(ew, et, etot);
    tick;
    checkOutput("doneClearAtStart", 32'(bus.Done), 0);
    checkOutput("validClearAtStart", 32'(bus.Show_Valid), 0);
    scrambleInputs();
    if (glitchInCmp) bus.Finish = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick;
      if (glitchInCmp && j == 0) bus.Finish = 1'b1;
      checkOutput("doneLowInCmp", 32'(bus.Done), 0);
    end
    tick;
    checkOutput("winner", 32'(bus.Winner), 32'(ew));
    checkOutput("tie", 32'(bus.Tie), 32'(et));
    checkOutput("total", 32'(bus.Total), 32'(etot));
    checkOutput("done", 32'(bus.Done), 1);
    checkOutput("showIdFirst", 32'(bus.Show_Id), 1);
    checkOutput("showCountFirst", 32'(bus.Show_Count), 32'(mC[1]));
    checkOutput("showValid", 32'(bus.Show_Valid), 1);
  endtask

  // Display rotation starting from the k+5 cycle.
  task automatic checkShow(input int cycles);
    int id;
    for (int n = 0; n < cycles; n++) begin
      id = ((n / DC) % 5) + 1;
      checkOutput("showId", 32'(bus.Show_Id), 32'(id));
      checkOutput("showCount", 32'(bus.Show_Count), 32'(mC[id]));
      if (n == 5) scrambleInputs();
      tick;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Winner"}, 32'(bus.Winner), 0);
    checkOutput({tag, "Tie"}, 32'(bus.Tie), 0);
    checkOutput({tag, "Total"}, 32'(bus.Total), 0);
    checkOutput({tag, "Done"}, 32'(bus.Done), 0);
    checkOutput({tag, "ShowId"}, 32'(bus.Show_Id), 0);
    checkOutput({tag, "ShowCount"}, 32'(bus.Show_Count), 0);
    checkOutput({tag, "ShowValid"}, 32'(bus.Show_Valid), 0);
  endtask

  task automatic idleFinish;
    bus.Finish = 1'b0;
    tick;
  endtask

  // Main sequence: directed cases, then randomized elections.
  initial begin
    int ew, et, etot, mode;
    reset = 1'b1;
    bus.Finish = 1'b0;
    bus.C1 = '0; bus.C2 = '0; bus.C3 = '0; bus.C4 = '0; bus.Nulo = '0;
    tick; tick;
    checkAllZero("reset");
    reset = 1'b0;
    tick;

    applyStimulus(8'd3, 8'd7, 8'd2, 8'd0, 8'd1);
    expectTally(1'b0);
    checkOutput("directWinner", 32'(bus.Winner), 2);
    checkOutput("directTotal", 32'(bus.Total), 13);
    checkShow(12);
    idleFinish();

    applyStimulus(8'd5, 8'd5, 8'd1, 8'd0, 8'd0);
    expectTally(1'b0);
    checkOutput("directTie", 32'(bus.Tie), 1);
    checkOutput("directTieTotal", 32'(bus.Total), 11);
    idleFinish();

    applyStimulus(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    expectTally(1'b0);
    checkOutput("zeroTie", 32'(bus.Tie), 0);
    idleFinish();

    applyStimulus(8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    expectTally(1'b0);
    checkOutput("maxTotal", 32'(bus.Total), 1275);
    idleFinish();

    // Finish held high: one tally only, results stay put.
    applyStimulus(8'd9, 8'd4, 8'd12, 8'd1, 8'd6);
    expectTally(1'b0);
    tallyModel(ew, et, etot);
    for (int j = 0; j < 15; j++) begin
      tick;
      checkOutput("heldDone", 32'(bus.Done), 1);
      checkOutput("heldTotal", 32'(bus.Total), 32'(etot));
    end
    idleFinish();

    // Second rising edge of Finish while comparing must be ignored.
    applyStimulus(8'd1, 8'd2, 8'd30, 8'd30, 8'd3);
    expectTally(1'b1);
    idleFinish();

    // Reset mid-compare: everything clears and no result ever shows.
    applyStimulus(8'd8, 8'd1, 8'd1, 8'd1, 8'd1);
    tick; tick; tick;
    reset = 1'b1;
    bus.Finish = 1'b0;
    tick;
    checkAllZero("abort");
    reset = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick;
      checkOutput("abortNoDone", 32'(bus.Done), 0);
    end

    // Reset coinciding with Finish rising: tally begins after release.
    applyStimulus(8'd2, 8'd6, 8'd6, 8'd7, 8'd0);
    reset = 1'b1;
    tick;
    checkOutput("resetStartDone", 32'(bus.Done), 0);
    checkOutput("resetStartValid", 32'(bus.Show_Valid), 0);
    reset = 1'b0;
    expectTally(1'b0);
    idleFinish();

    // Randomized elections, restarting from SHOW each time.
    for (int r = 0; r < 25; r++) begin
      mode = int'($urandom_range(0, 2));
      if (mode == 0)
        applyStimulus(8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                      8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)));
      else if (mode == 1)
        applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      else
        applyStimulus(8'd255, 8'($urandom_range(250, 255)), 8'($urandom_range(250, 255)),
                      8'($urandom_range(250, 255)), 8'($urandom));
      expectTally(1'b0);
      checkShow(DC * 5 + 2);
      idleFinish();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
